// File: rtl/vec_pkg.sv
// vec_pkg: shared vector-pipeline widths, writeback packet layout and ALU encodings.
package vec_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int PKT_W    = ADDR_W + DATA_W;
    // Packet is big-endian: bit 0 is the MSB of the destination index.
    localparam int DEST_MSB = 0;
    localparam int DEST_LSB = ADDR_W - 1;
    localparam int DATA_MSB = ADDR_W;
    localparam int DATA_LSB = PKT_W - 1;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_ELEM_W = 2;
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_MUL
    } alu_op_e;
    typedef enum logic [ALU_ELEM_W-1:0] {ELEM_8, ELEM_16, ELEM_32, ELEM_64} alu_elem_e;
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_pkt_t;
endpackage

// File: rtl/vec_wb_fifo.sv
// vec_wb_fifo: DEPTH-entry writeback packet FIFO; entries are exposed oldest-first
// with per-entry valid bits so the stage can do hazard and forwarding compares.
module vec_wb_fifo
    import vec_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  wb_pkt_t                        pkt_i,
    output wb_pkt_t                        head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]   ent_dest_o,
    output logic [DEPTH-1:0][DATA_W-1:0]   ent_data_o,
    output logic [DEPTH-1:0]               ent_vld_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_pkt_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign head_d = pop_i ? head_q + PTR_W'(1) : head_q;
    assign tail_d = push_i ? tail_q + PTR_W'(1) : tail_q;
    assign cnt_d  = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) mem_q[tail_q] <= pkt_i;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = cnt_q;

    // Rotate into age order: index 0 is the head, higher indices are younger.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_dest_o[i] = mem_q[head_q + PTR_W'(i)].dest;
            ent_data_o[i] = mem_q[head_q + PTR_W'(i)].data;
            ent_vld_o[i]  = CNT_W'(i) < cnt_q;
        end
    end
endmodule

// File: rtl/vec_wb_stage.sv
// vec_wb_stage: ALU writeback FIFO draining into a 32x64 register file with two read ports.
// VEC_WB_BYPASS_EN forwards the youngest pending FIFO write to the read ports.
module vec_wb_stage
    import vec_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [0:PKT_W-1]              in_pkt,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          wb_hold,
    input  logic [ADDR_W-1:0]             rd_addr_a,
    output logic [DATA_W-1:0]             rd_data_a,
    input  logic [ADDR_W-1:0]             rd_addr_b,
    output logic [DATA_W-1:0]             rd_data_b,
    output logic                          rd_hazard_a,
    output logic                          rd_hazard_b,
    output logic [$clog2(DEPTH+1)-1:0]    wb_count,
    output logic                          wb_commit
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic push, pop;
    wb_pkt_t pkt_in, head;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_dest;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0] ent_vld;
    logic [NUM_REGS-1:0][DATA_W-1:0] rf_q;
    logic commit_q;

    assign pkt_in.dest = in_pkt[DEST_MSB:DEST_LSB];
    assign pkt_in.data = in_pkt[DATA_MSB:DATA_LSB];
    assign in_ready    = !reset && wb_count != CNT_W'(DEPTH);
    assign push        = in_valid && in_ready;
    assign pop         = wb_count != '0 && !wb_hold;
    assign wb_commit   = commit_q;

    vec_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .pkt_i      (pkt_in),
        .head_o     (head),
        .count_o    (wb_count),
        .ent_dest_o (ent_dest),
        .ent_data_o (ent_data),
        .ent_vld_o  (ent_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_q     <= '0;
            commit_q <= 1'b0;
        end else begin
            if (pop) rf_q[head.dest] <= head.data;
            commit_q <= pop;
        end
    end

    // Scanning oldest to youngest lets the youngest match win the forward.
    always_comb begin
        rd_hazard_a = 1'b0;
        rd_hazard_b = 1'b0;
        rd_data_a   = rf_q[rd_addr_a];
        rd_data_b   = rf_q[rd_addr_b];
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_dest[i] == rd_addr_a) begin
                rd_hazard_a = 1'b1;
`ifdef VEC_WB_BYPASS_EN
                rd_data_a = ent_data[i];
`endif
            end
            if (ent_vld[i] && ent_dest[i] == rd_addr_b) begin
                rd_hazard_b = 1'b1;
`ifdef VEC_WB_BYPASS_EN
                rd_data_b = ent_data[i];
`endif
            end
        end
    end

`ifndef VEC_WB_BYPASS_EN
    logic unused_fwd;
    assign unused_fwd = ^ent_data;
`endif
endmodule

// File: tb/tb_vec_wb_stage.sv
// tb_vec_wb_stage: queue-based reference model compared every cycle, plus directed literal checks.
module tb_vec_wb_stage;
    import vec_pkg::*;
    localparam int DEPTH = 2;
`ifdef VEC_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0;
    logic [0:PKT_W-1] in_pkt;
    logic in_valid, in_ready, wb_hold;
    logic [4:0] rd_addr_a, rd_addr_b;
    logic [63:0] rd_data_a, rd_data_b;
    logic rd_hazard_a, rd_hazard_b, wb_commit;
    logic [1:0] wb_count;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    vec_wb_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_pkt(in_pkt), .in_valid(in_valid), .in_ready(in_ready),
        .wb_hold(wb_hold), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_hazard_a(rd_hazard_a),
        .rd_hazard_b(rd_hazard_b), .wb_count(wb_count), .wb_commit(wb_commit)
    );

    // Reference model: pending writes as a queue of {dest, data}, plus the register array.
    logic [68:0] mq[$];
    logic [63:0] mregs[32];
    bit mcommit;

    always @(posedge clk or posedge reset) begin : model
        bit acc, dr;
        if (reset) begin
            mq = {};
            foreach (mregs[i]) mregs[i] = '0;
            mcommit = 1'b0;
        end else begin
            acc = in_valid && mq.size() < DEPTH;
            dr  = mq.size() > 0 && !wb_hold;
            if (dr) begin
                mregs[mq[0][68:64]] = mq[0][63:0];
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(in_pkt);
            mcommit = dr;
        end
    end

    function automatic logic [63:0] exp_rd(logic [4:0] a);
        logic [63:0] r = mregs[a];
        if (BYP) foreach (mq[i]) if (mq[i][68:64] == a) r = mq[i][63:0];
        return r;
    endfunction

    function automatic logic exp_hz(logic [4:0] a);
        foreach (mq[i]) if (mq[i][68:64] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_wb_count", wb_count, 0);
            chk("rst_wb_commit", wb_commit, 0);
        end else begin
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("wb_count", wb_count, mq.size());
            chk("wb_commit", wb_commit, mcommit);
            chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
            chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
            chk("rd_hazard_a", rd_hazard_a, exp_hz(rd_addr_a));
            chk("rd_hazard_b", rd_hazard_b, exp_hz(rd_addr_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(bit v, logic [4:0] d, logic [63:0] x, bit h);
        in_valid = v;
        in_pkt   = {d, x};
        wb_hold  = h;
    endtask

    localparam logic [63:0] V7 = 64'h0123_4567_89AB_CDEF;

    initial begin
        bit held;
        drive(0, 0, 0, 0);
        rd_addr_a = 0;
        rd_addr_b = 0;
        #1 reset = 1'b1;
        #1 chk("lit_ready_in_reset", in_ready, 0);
        tick();
        tick();
        reset = 1'b0;
        #1 chk("lit_ready_after_reset", in_ready, 1);
        // Single write to idx 7
        drive(1, 7, V7, 0);
        rd_addr_a = 7;
        tick();
        in_valid = 0;
        chk("lit_sw_count", wb_count, 1);
        chk("lit_sw_hazard", rd_hazard_a, 1);
        chk("lit_sw_commit0", wb_commit, 0);
        chk("lit_sw_data_pending", rd_data_a, BYP ? V7 : 64'h0);
        tick();
        chk("lit_sw_commit1", wb_commit, 1);
        chk("lit_sw_data_written", rd_data_a, V7);
        chk("lit_sw_hazard_clear", rd_hazard_a, 0);
        tick();
        chk("lit_sw_commit_pulse", wb_commit, 0);
        chk("lit_sw_data_kept", rd_data_a, V7);
        // Backpressure: three packets while held
        rd_addr_b = 4;
        drive(1, 1, 64'h1111, 1);
        tick();
        chk("lit_bp_count1", wb_count, 1);
        drive(1, 2, 64'h2222, 1);
        tick();
        chk("lit_bp_count2", wb_count, 2);
        chk("lit_bp_not_ready", in_ready, 0);
        drive(1, 4, 64'h3333, 1);
        tick();
        chk("lit_bp_held_count", wb_count, 2);
        chk("lit_bp_third_not_taken", rd_hazard_b, 0);
        wb_hold = 0;
        tick();
        chk("lit_bp_full_refused", wb_count, 1);
        chk("lit_bp_pop1_commit", wb_commit, 1);
        rd_addr_a = 1;
        #1 chk("lit_bp_reg1", rd_data_a, 64'h1111);
        tick();
        in_valid = 0;
        chk("lit_bp_third_taken", rd_hazard_b, 1);
        chk("lit_bp_count_swap", wb_count, 1);
        rd_addr_a = 2;
        #1 chk("lit_bp_reg2", rd_data_a, 64'h2222);
        tick();
        chk("lit_bp_drained", wb_count, 0);
        chk("lit_bp_reg4", rd_data_b, 64'h3333);
        // Same-index ordering
        rd_addr_a = 3;
        drive(1, 3, 64'hAA, 1);
        tick();
        drive(1, 3, 64'hBB, 1);
        tick();
        in_valid = 0;
        chk("lit_same_hazard", rd_hazard_a, 1);
        chk("lit_same_pending", rd_data_a, BYP ? 64'hBB : 64'h0);
        wb_hold = 0;
        tick();
        chk("lit_same_hazard_mid", rd_hazard_a, 1);
        chk("lit_same_mid", rd_data_a, BYP ? 64'hBB : 64'hAA);
        tick();
        chk("lit_same_hazard_done", rd_hazard_a, 0);
        chk("lit_same_final", rd_data_a, 64'hBB);
        // Forwarding of youngest pending write
        rd_addr_b = 5;
        drive(1, 5, 64'h11, 1);
        tick();
        drive(1, 5, 64'h22, 1);
        tick();
        in_valid = 0;
        chk("lit_fwd_data", rd_data_b, BYP ? 64'h22 : 64'h0);
        chk("lit_fwd_hazard", rd_hazard_b, 1);
        wb_hold = 0;
        tick();
        tick();
        chk("lit_fwd_final", rd_data_b, 64'h22);
        // Continuous stream at occupancy 1
        for (int k = 0; k < 8; k++) begin
            drive(1, 5'(10 + k), 64'hC0DE_0000 + 64'(k), 0);
            tick();
            chk("lit_stream_count", wb_count, 1);
            if (k > 0) chk("lit_stream_commit", wb_commit, 1);
        end
        in_valid = 0;
        tick();
        chk("lit_stream_last_commit", wb_commit, 1);
        for (int k = 0; k < 8; k++) begin
            rd_addr_a = 5'(10 + k);
            #1 chk("lit_stream_reg", rd_data_a, 64'hC0DE_0000 + 64'(k));
        end
        // Reset with two packets pending
        drive(1, 20, 64'hDEAD, 1);
        tick();
        drive(1, 21, 64'hBEEF, 1);
        tick();
        in_valid = 0;
        chk("lit_mid_pending", wb_count, 2);
        reset = 1'b1;
        #1 chk("lit_mid_rst_count", wb_count, 0);
        tick();
        tick();
        reset = 1'b0;
        wb_hold = 0;
        tick();
        chk("lit_mid_no_commit", wb_commit, 0);
        chk("lit_mid_count", wb_count, 0);
        for (int k = 0; k < 32; k++) begin
            rd_addr_a = 5'(k);
            #1 chk("lit_mid_reg_zero", rd_data_a, 64'h0);
        end
        // Randomised traffic; a refused packet is held stable until accepted
        held = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!held) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_pkt   = {5'($urandom_range(0, 31)), $urandom, $urandom};
            end
            wb_hold   = $urandom_range(0, 3) == 0;
            rd_addr_a = 5'($urandom);
            rd_addr_b = $urandom_range(0, 1) ? in_pkt[0:4] : 5'($urandom);
            reset     = $urandom_range(0, 499) == 0;
            #1 held = in_valid && !in_ready;
            tick();
        end
        reset = 1'b0;
        in_valid = 0;
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
